// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stage indices, FSM encodings and enable levels for pipe_ctrl
package pipe_ctrl_pkg;

  // Stage indices into the stall/flush vectors (EX is always NUM_STAGES-1)
  localparam int STAGE_PC = 0;
  localparam int STAGE_IF = 1;
  localparam int STAGE_ID = 2;
  localparam int STAGE_EX = 3;

  // Active levels understood by pc_reg and the pipeline registers
  localparam logic JUMP_ENABLE = 1'b1;
  localparam logic HOLD_ENABLE = 1'b1;

  // Redirect controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_PEND  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_ctrl_hold_watchdog.sv
// rtl/pipe_ctrl_hold_watchdog.sv - counts consecutive bus-hold cycles and pulses once at the limit
module pipe_ctrl_hold_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic rib_hold,
  output logic busy_timeout
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  // A zero limit turns the watchdog off entirely
  localparam logic ENABLED = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] r_cnt;

  // Count hold cycles, saturating at the limit so the pulse cannot repeat until hold drops
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!rib_hold) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Fire in the cycle whose hold makes the count reach the limit
  assign busy_timeout = ENABLED & ~rst & rib_hold & (r_cnt == (LIMIT - CW'(1)));

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - redirect arbitration, flush windows, pending redirect and stall generation
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int NUM_STAGES     = 4,
  parameter int FLUSH_CYCLES   = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_jump_flag,
  input  logic [ADDR_W-1:0]     ex_jump_addr,
  input  logic                  clint_jump_flag,
  input  logic [ADDR_W-1:0]     clint_jump_addr,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic                  rib_hold,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  pc_jump_flag,
  output logic [ADDR_W-1:0]     pc_jump_addr,
  output logic                  jump_pending,
  output logic                  busy_timeout
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic MULTI_FLUSH = (FLUSH_CYCLES > 1);
  // Only the stages between PC and EX receive bubbles
  localparam logic [NUM_STAGES-1:0] FLUSH_MASK = {1'b0, {(NUM_STAGES-2){1'b1}}, 1'b0};

  pipe_state_e             r_state;
  pipe_state_e             w_next_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_next_cnt;
  logic [ADDR_W-1:0]       r_pend_addr;
  logic [ADDR_W-1:0]       w_next_pend_addr;

  logic                    w_jump_req;
  logic [ADDR_W-1:0]       w_sel_addr;
  logic [ADDR_W-1:0]       w_release_addr;
  logic [NUM_STAGES-1:0]   w_stall_raw;
  logic                    w_flush_on;

  // CLINT always wins over EX
  assign w_jump_req     = ex_jump_flag | clint_jump_flag;
  assign w_sel_addr     = clint_jump_flag ? clint_jump_addr : ex_jump_addr;
  // A trap arriving in the release cycle supersedes the buffered target
  assign w_release_addr = clint_jump_flag ? clint_jump_addr : r_pend_addr;

  // State register: FSM state, flush countdown and buffered redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_pend_addr <= '0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_pend_addr <= w_next_pend_addr;
    end
  end

  // Next-state logic: a new redirect always restarts the window; EX is ignored while pending
  always_comb begin
    w_next_state     = r_state;
    w_next_cnt       = r_cnt;
    w_next_pend_addr = r_pend_addr;
    case (r_state)
      ST_IDLE, ST_FLUSH: begin
        if (w_jump_req && !rib_hold) begin
          w_next_state = MULTI_FLUSH ? ST_FLUSH : ST_IDLE;
          w_next_cnt   = FLUSH_RELOAD;
        end else if (w_jump_req) begin
          w_next_state     = ST_PEND;
          w_next_pend_addr = w_sel_addr;
        end else if (r_state == ST_FLUSH) begin
          if (r_cnt <= CNT_W'(1)) begin
            w_next_state = ST_IDLE;
          end else begin
            w_next_cnt = r_cnt - CNT_W'(1);
          end
        end
      end
      ST_PEND: begin
        if (!rib_hold) begin
          w_next_state = MULTI_FLUSH ? ST_FLUSH : ST_IDLE;
          w_next_cnt   = FLUSH_RELOAD;
        end else if (clint_jump_flag) begin
          w_next_pend_addr = clint_jump_addr;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Stage i holds when it or any downstream stage asks; PC also holds on a busy bus
  always_comb begin
    w_stall_raw = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_stall_raw[i] = |(stall_req >> i);
    end
    w_stall_raw[STAGE_PC] = w_stall_raw[STAGE_PC] | rib_hold;
  end

  // Output logic: redirect, flush window and stall vectors, all silenced during reset
  always_comb begin
    pc_jump_flag = 1'b0;
    pc_jump_addr = '0;
    jump_pending = 1'b0;
    w_flush_on   = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_IDLE, ST_FLUSH: begin
          if (w_jump_req) begin
            w_flush_on = 1'b1;
            if (!rib_hold) begin
              pc_jump_flag = JUMP_ENABLE;
              pc_jump_addr = w_sel_addr;
            end
          end else if (r_state == ST_FLUSH) begin
            w_flush_on = 1'b1;
          end
        end
        ST_PEND: begin
          w_flush_on   = 1'b1;
          jump_pending = 1'b1;
          if (!rib_hold) begin
            pc_jump_flag = JUMP_ENABLE;
            pc_jump_addr = w_release_addr;
          end
        end
        default: begin
          w_flush_on = 1'b0;
        end
      endcase
    end
    flush = w_flush_on ? FLUSH_MASK : '0;
    stall = rst ? '0 : (w_stall_raw & ~flush);
    if (!rst && r_state == ST_PEND) begin
      stall[STAGE_PC] = HOLD_ENABLE;
    end
  end

  pipe_ctrl_hold_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_hold_watchdog (
    .clk         (clk),
    .rst         (rst),
    .rib_hold    (rib_hold),
    .busy_timeout(busy_timeout)
  );

endmodule
